// File: rtl/act_stack.sv
// Accumulator with registered flags and a DEPTH-entry LIFO for saving and restoring the accumulator.
// Define ACT_SAT_EN to make ADD/SUB saturate as unsigned instead of wrapping.
module act_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SP_W = $clog2(DEPTH + 1)
) (
  input  logic             C_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             cy_o,
  output logic             z_o,
  output logic             ov_o,
  output logic [SP_W-1:0]  sp_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             push_ok;
  logic [WIDTH-1:0] pop_val;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign sum  = {1'b0, acc_q} + {1'b0, d_i};
  assign diff = {1'b0, acc_q} - {1'b0, d_i};

  // Top-of-stack read: entry sp-1
  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) pop_val = stack_q[i];
    end
  end

  // Next-state and flag computation
  always_comb begin
    acc_d   = acc_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    sp_d    = sp_q;
    z_d     = z_q;
    empty_d = empty_q;
    full_d  = full_q;
    err_d   = 1'b0;
    push_ok = 1'b0;
    if (en_i) begin
      case (op_i)
        OP_NOP: ;
        OP_LOAD: begin
          acc_d = d_i;
          cy_d  = 1'b0;
          ov_d  = 1'b0;
        end
        OP_ADD: begin
`ifdef ACT_SAT_EN
          acc_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
          acc_d = sum[WIDTH-1:0];
`endif
          cy_d  = sum[WIDTH];
          ov_d  = (acc_q[WIDTH-1] == d_i[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
        end
        OP_SUB: begin
`ifdef ACT_SAT_EN
          acc_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
          acc_d = diff[WIDTH-1:0];
`endif
          cy_d  = diff[WIDTH];
          ov_d  = (acc_q[WIDTH-1] != d_i[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
        end
        OP_SHL: begin
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
          cy_d  = acc_q[WIDTH-1];
          ov_d  = 1'b0;
        end
        OP_SHR: begin
          acc_d = {1'b0, acc_q[WIDTH-1:1]};
          cy_d  = acc_q[0];
          ov_d  = 1'b0;
        end
        OP_PUSH: begin
          if (full_q) err_d = 1'b1;
          else begin
            push_ok = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        OP_POP: begin
          if (empty_q) err_d = 1'b1;
          else begin
            acc_d = pop_val;
            sp_d  = sp_q - SP_W'(1);
          end
        end
        default: ;
      endcase
      z_d     = (acc_d == '0);
      empty_d = (sp_d == '0);
      full_d  = (sp_d == SP_W'(DEPTH));
    end
  end

  always_ff @(posedge C_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b1;
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
      sp_q    <= sp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // LIFO storage is never read while empty, so it carries no reset
  always_ff @(posedge C_i) begin
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SP_W'(i)) stack_q[i] <= acc_q;
      end
    end
  end

  assign acc_o   = acc_q;
  assign cy_o    = cy_q;
  assign ov_o    = ov_q;
  assign z_o     = z_q;
  assign sp_o    = sp_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_act_stack.sv
// Scoreboard bench for act_stack: arithmetic reference model feeds an expectation queue
// that a negedge monitor drains against the registered outputs.
module tb_act_stack;

  localparam int unsigned W    = 4;
  localparam int unsigned D    = 2;
  localparam int unsigned SP_W = $clog2(D + 1);
  localparam int          M    = 1 << W;
  localparam int          HALF = 1 << (W - 1);

  logic          C_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          en_i = 1'b0;
  logic [2:0]    op_i = 3'b000;
  logic [W-1:0]  d_i = '0;
  logic [W-1:0]  acc_o;
  logic          cy_o, z_o, ov_o, empty_o, full_o, err_o;
  logic [SP_W-1:0] sp_o;

  act_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .C_i(C_i), .rst_i(rst_i), .en_i(en_i), .op_i(op_i), .d_i(d_i),
    .acc_o(acc_o), .cy_o(cy_o), .z_o(z_o), .ov_o(ov_o), .sp_o(sp_o),
    .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 C_i = ~C_i;

  typedef struct {
    int acc, cy, z, ov, sp, empty, full, err;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state
  int m_acc, m_cy, m_ov, m_err;
  int m_stack[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    else passed++;
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - M : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cy = 0; m_ov = 0; m_err = 0;
    m_stack.delete();
  endtask

  task automatic model_op(input bit en, input int op, input int d);
    int r, sr;
    m_err = 0;
    if (!en) return;
    case (op)
      1: begin m_acc = d; m_cy = 0; m_ov = 0; end
      2: begin
        r  = m_acc + d;
        sr = sgn(m_acc) + sgn(d);
        m_cy = (r >= M);
        m_ov = (sr >= HALF || sr < -HALF);
`ifdef ACT_SAT_EN
        m_acc = m_cy ? M - 1 : r;
`else
        m_acc = r % M;
`endif
      end
      3: begin
        r  = m_acc - d;
        sr = sgn(m_acc) - sgn(d);
        m_cy = (m_acc < d);
        m_ov = (sr >= HALF || sr < -HALF);
`ifdef ACT_SAT_EN
        m_acc = m_cy ? 0 : r;
`else
        m_acc = (r + M) % M;
`endif
      end
      4: begin m_cy = (m_acc >= HALF); m_acc = (m_acc * 2) % M; m_ov = 0; end
      5: begin m_cy = m_acc % 2; m_acc = m_acc / 2; m_ov = 0; end
      6: if (m_stack.size() == D) m_err = 1; else m_stack.push_back(m_acc);
      7: if (m_stack.size() == 0) m_err = 1; else m_acc = m_stack.pop_back();
      default: ;
    endcase
  endtask

  function automatic exp_t model_snap(input string tag);
    exp_t e;
    e.acc = m_acc; e.cy = m_cy; e.ov = m_ov; e.z = (m_acc == 0);
    e.sp = m_stack.size(); e.empty = (m_stack.size() == 0);
    e.full = (m_stack.size() == D); e.err = m_err; e.tag = tag;
    return e;
  endfunction

  // One op per call; inputs return to idle so extra edges only hold state
  task automatic step(input bit en, input int op, input int d, input string tag);
    en_i = en; op_i = 3'(op); d_i = W'(d);
    @(posedge C_i);
    model_op(en, op, d);
    exp_q.push_back(model_snap(tag));
    @(negedge C_i);
    en_i = 1'b0; op_i = 3'b000; d_i = '0;
  endtask

  // Monitor: compares every registered output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge C_i);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".acc"},   int'(acc_o),   e.acc);
        chk({e.tag, ".cy"},    int'(cy_o),    e.cy);
        chk({e.tag, ".z"},     int'(z_o),     e.z);
        chk({e.tag, ".ov"},    int'(ov_o),    e.ov);
        chk({e.tag, ".sp"},    int'(sp_o),    e.sp);
        chk({e.tag, ".empty"}, int'(empty_o), e.empty);
        chk({e.tag, ".full"},  int'(full_o),  e.full);
        chk({e.tag, ".err"},   int'(err_o),   e.err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge C_i);
    chk("rst.acc", int'(acc_o), 0);
    chk("rst.z", int'(z_o), 1);
    chk("rst.empty", int'(empty_o), 1);
    chk("rst.err", int'(err_o), 0);
    rst_i = 1'b1;
    @(negedge C_i);

    // Async reset mid-cycle after a few ops
    step(1, 1, 4'h6, "pre1");
    step(1, 6, 0, "pre2");
    step(1, 2, 4'h3, "pre3");
    @(posedge C_i); #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("arst.acc", int'(acc_o), 0);
    chk("arst.z", int'(z_o), 1);
    chk("arst.sp", int'(sp_o), 0);
    chk("arst.empty", int'(empty_o), 1);
    chk("arst.cy", int'(cy_o), 0);
    @(negedge C_i);
    rst_i = 1'b1;
    step(1, 1, 4'h5, "ld5");

    // Arithmetic corners
    step(1, 1, 4'hF, "ldF");  step(1, 2, 4'h1, "addwrap");
    step(1, 1, 4'h7, "ld7");  step(1, 2, 4'h1, "addov");
    step(1, 1, 4'h2, "ld2");  step(1, 3, 4'h3, "subbor");
    step(1, 1, 4'h8, "ld8");  step(1, 3, 4'h1, "subov");
    step(1, 1, 4'hE, "ldE");  step(1, 2, 4'h5, "addsat");
    step(1, 1, 4'h1, "ld1");  step(1, 3, 4'h2, "subsat");

    // Shifts
    step(1, 1, 4'h9, "ld9");
    step(1, 4, 0, "shl"); step(1, 5, 0, "shr1"); step(1, 5, 0, "shr2");
    step(1, 0, 4'h7, "nop");

    // LIFO boundary
    step(1, 1, 3, "ld3"); step(1, 6, 0, "push1");
    step(1, 1, 9, "ld9b"); step(1, 6, 0, "push2");
    step(1, 6, 0, "pushfull"); step(1, 0, 0, "errclr");
    step(1, 1, 0, "ld0"); step(1, 7, 0, "pop1"); step(1, 7, 0, "pop2");
    step(1, 7, 0, "popempty"); step(1, 0, 0, "errclr2");

    // Enable gating
    step(0, 1, 4'hA, "gated"); step(0, 7, 0, "gatedpop");
    step(1, 1, 4'hA, "ungated");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, int'($urandom % 8), int'($urandom % M), "rnd");
    end

    repeat (2) @(negedge C_i);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
